switch_capture: RTL and testbench

- Input-side front end for the ALU board design: turns raw board switches and pushbuttons into clean, registered operand/opcode values and a one-cycle load strobe.
- Feeds the ALU's 8-bit operand and 3-bit opcode; the seven-segment scanner shows the result.
- All raw inputs are asynchronous to clk. They are synchronized, the buttons are debounced, and values are captured only on a debounced press.

---
 rtl/switch_capture_pkg.sv | 15 +
 rtl/switch_capture_if.sv | 24 ++
 rtl/switch_capture_btn_debounce.sv | 69 ++++++
 rtl/switch_capture.sv | 99 +++++++++
 tb/tb_switch_capture.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_capture_pkg.sv
// Shared types and widths for the switch/button capture front end of the ALU board.
package switch_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } dbnc_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int OPERAND_W   = 8;
  localparam int OPCODE_W    = 3;

endpackage

// File: rtl/switch_capture_if.sv
// Board-side bundle: raw switches/buttons in, captured operand/opcode and load status out.
interface switch_capture_if;
  import switch_capture_pkg::*;

  logic [OPERAND_W-1:0] sw_data;
  logic [OPCODE_W-1:0]  sw_op;
  logic                 btn_load;
  logic                 btn_clr;
  logic [OPERAND_W-1:0] ins;
  logic [OPCODE_W-1:0]  op;
  logic                 load_pulse;
  logic [7:0]           load_cnt;

  modport master (
    output sw_data, sw_op, btn_load, btn_clr,
    input  ins, op, load_pulse, load_cnt
  );

  modport slave (
    input  sw_data, sw_op, btn_load, btn_clr,
    output ins, op, load_pulse, load_cnt
  );

endinterface

// File: rtl/switch_capture_btn_debounce.sv
// One pushbutton: synchronizer, debounce counter and FSM; press_evt pulses once per accepted press.
module btn_debounce
  import switch_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  dbnc_state_t            state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchronized level -> debounced press event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (synced) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!synced) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state     <= HELD;
            press_evt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!synced) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (synced)           state <= HELD;
          else if (cnt == LAST) state <= IDLE;
          else                  cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/switch_capture.sv
// Switch/button capture for the ALU board. Optional switch stability filter: define
// SWITCH_CAPTURE_SW_DEBOUNCE_EN; otherwise switches are only synchronized.
module switch_capture
  import switch_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic             clk,
  input logic             reset,
  switch_capture_if.slave bus
);

  localparam int SW_W = OPERAND_W + OPCODE_W;

  logic                            load_evt;
  logic                            clr_evt;
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync;
  logic [SW_W-1:0]                 sw_cur;
  logic [SW_W-1:0]                 sw_cap;
  logic [OPERAND_W-1:0]            ins_q;
  logic [OPCODE_W-1:0]             op_q;
  logic                            pulse_q;
  logic [7:0]                      cnt_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (bus.btn_load),
    .press_evt (load_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clr (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (bus.btn_clr),
    .press_evt (clr_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sw_sync <= '0;
    else        sw_sync <= {sw_sync[SYNC_STAGES-2:0], {bus.sw_data, bus.sw_op}};
  end

  assign sw_cur = sw_sync[SYNC_STAGES-1];

`ifdef SWITCH_CAPTURE_SW_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sw_prev;
  logic [SW_W-1:0]  sw_stable;
  logic [CNT_W-1:0] sw_cnt;

  // Any change restarts the stability window; only a full quiet window updates sw_stable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_prev   <= '0;
      sw_stable <= '0;
      sw_cnt    <= '0;
    end else begin
      sw_prev <= sw_cur;
      if (sw_cur != sw_prev)  sw_cnt    <= '0;
      else if (sw_cnt != LAST) sw_cnt   <= sw_cnt + 1'b1;
      else                    sw_stable <= sw_cur;
    end
  end

  assign sw_cap = sw_stable;
`else
  assign sw_cap = sw_cur;
`endif

  // Capture stage: clear has priority over a coincident load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_q   <= '0;
      op_q    <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      if (clr_evt) begin
        ins_q <= '0;
        op_q  <= '0;
      end else if (load_evt) begin
        ins_q   <= sw_cap[SW_W-1:OPCODE_W];
        op_q    <= sw_cap[OPCODE_W-1:0];
        cnt_q   <= cnt_q + 8'd1;
        pulse_q <= 1'b1;
      end
    end
  end

  assign bus.ins        = ins_q;
  assign bus.op         = op_q;
  assign bus.load_pulse = pulse_q;
  assign bus.load_cnt   = cnt_q;

endmodule

// File: tb/tb_switch_capture.sv
// Bench for switch_capture with a run-length (hysteresis) model of the button debounce.
module tb_switch_capture;

  localparam int D     = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  switch_capture_if bus ();

  switch_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]  m_ins, m_cnt;
  logic [2:0]  m_op;
  logic        m_pulse;
  logic [1:0]  bh [2];
  int          run1 [2];
  int          run0 [2];
  bit          pressed [2];
  bit          ev [2];
  logic [10:0] swh0, swh1;

  task automatic model_clear();
    m_ins = '0; m_op = '0; m_pulse = 1'b0; m_cnt = '0;
    swh0 = '0; swh1 = '0;
    for (int b = 0; b < 2; b++) begin
      bh[b] = '0; run1[b] = 0; run0[b] = 0; pressed[b] = 0; ev[b] = 0;
    end
  endtask

  // A level is accepted after D+1 consecutive synchronized samples; one event per accepted press
  task automatic tick();
    logic [1:0] raw;
    @(posedge clk);
    raw = {bus.btn_clr, bus.btn_load};
    if (!reset) begin
      model_clear();
    end else begin
      m_pulse = 1'b0;
      if (ev[1]) begin
        m_ins = '0; m_op = '0;
      end else if (ev[0]) begin
        m_ins = swh1[10:3]; m_op = swh1[2:0]; m_cnt = m_cnt + 8'd1; m_pulse = 1'b1;
      end
      for (int b = 0; b < 2; b++) begin
        if (bh[b][1]) begin run1[b]++; run0[b] = 0; end
        else          begin run0[b]++; run1[b] = 0; end
        ev[b] = 0;
        if (!pressed[b] && run1[b] == D + 1) begin ev[b] = 1; pressed[b] = 1; end
        else if (pressed[b] && run0[b] == D + 1) pressed[b] = 0;
        bh[b] = {bh[b][0], raw[b]};
      end
      swh1 = swh0;
      swh0 = {bus.sw_data, bus.sw_op};
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int ptick;
    reset = 1'b0; bus.btn_load = 1'b1; bus.btn_clr = 1'b0;
    bus.sw_data = 8'h3C; bus.sw_op = 3'b101;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_hold ins=%h op=%h pulse=%b cnt=%0d required all zero",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt);
      end
    end
    reset = 1'b1;
    ptick = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.load_pulse === 1'b1 && ptick == 0) ptick = i;
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL reset_release ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (ptick != 8 || bus.ins !== 8'h3C) begin
      n_fail++;
      $display("FAIL reset_first_load pulse_tick=%0d ins=%h required 8 3c", ptick, bus.ins);
    end
    // Reset in the middle of a debounce must throw the partial count away
    bus.btn_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.btn_load = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    model_clear();
    #1;
    n_chk++;
    if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_async ins=%h op=%h pulse=%b cnt=%0d required all zero",
               bus.ins, bus.op, bus.load_pulse, bus.load_cnt);
    end
    @(negedge clk);
    tick();
    reset = 1'b1;
    ptick = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.load_pulse === 1'b1 && ptick == 0) ptick = i;
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL reset_mid ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (ptick != 8 || bus.load_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_mid_restart pulse_tick=%0d cnt=%0d required 8 1", ptick, bus.load_cnt);
    end
    bus.btn_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_clean_load();
    int ptick, npulse;
    logic [7:0] cnt0;
    cnt0 = m_cnt; ptick = 0; npulse = 0;
    bus.sw_data = 8'hA5; bus.sw_op = 3'b010;
    for (int i = 0; i < 4; i++) tick();
    bus.btn_load = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) begin
        bus.sw_data = 8'($urandom); bus.sw_op = 3'($urandom);
      end
      if (bus.load_pulse === 1'b1) begin npulse++; if (ptick == 0) ptick = i; end
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL clean_load ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (bus.ins !== 8'hA5 || bus.op !== 3'b010 || npulse != 1 || ptick != 8 ||
        bus.load_cnt !== cnt0 + 8'd1) begin
      n_fail++;
      $display("FAIL clean_load_result ins=%h op=%b pulses=%0d tick=%0d cnt=%0d required a5 010 1 8 %0d",
               bus.ins, bus.op, npulse, ptick, bus.load_cnt, cnt0 + 8'd1);
    end
    bus.btn_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_bounce();
    int ptick, npulse;
    logic [7:0] val;
    ptick = 0; npulse = 0;
    val = 8'($urandom) | 8'h01;
    bus.sw_data = val; bus.sw_op = 3'b110;
    for (int i = 1; i <= 24; i++) begin
      bus.btn_load = (i >= 5) ? 1'b1 : ((i % 2) == 1);
      tick();
      if (bus.load_pulse === 1'b1) begin npulse++; if (ptick == 0) ptick = i; end
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL bounce ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (npulse != 1 || ptick != 12 || bus.ins !== val) begin
      n_fail++;
      $display("FAIL bounce_result pulses=%0d tick=%0d ins=%h required 1 12 %h", npulse, ptick, bus.ins, val);
    end
    bus.btn_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_clear();
    int npulse;
    logic [7:0] cnt0;
    cnt0 = m_cnt; npulse = 0;
    bus.btn_clr = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.load_pulse === 1'b1) npulse++;
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL clear ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (bus.ins !== 8'h00 || bus.op !== 3'b000 || npulse != 0 || bus.load_cnt !== cnt0) begin
      n_fail++;
      $display("FAIL clear_result ins=%h op=%b pulses=%0d cnt=%0d required 00 000 0 %0d",
               bus.ins, bus.op, npulse, bus.load_cnt, cnt0);
    end
    bus.btn_clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_simultaneous();
    int npulse;
    logic [7:0] cnt0;
    bus.sw_data = 8'h5A; bus.sw_op = 3'b011;
    bus.btn_load = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.btn_load = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    cnt0 = m_cnt; npulse = 0;
    bus.sw_data = 8'($urandom) | 8'h80;
    bus.btn_load = 1'b1; bus.btn_clr = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (bus.load_pulse === 1'b1) npulse++;
      n_chk++;
      if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
        n_fail++;
        $display("FAIL simultaneous ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                 bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
      end
    end
    n_chk++;
    if (bus.ins !== 8'h00 || npulse != 0 || bus.load_cnt !== cnt0) begin
      n_fail++;
      $display("FAIL simultaneous_result ins=%h pulses=%0d cnt=%0d required 00 0 %0d",
               bus.ins, npulse, bus.load_cnt, cnt0);
    end
    bus.btn_load = 1'b0; bus.btn_clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_wrap();
    logic [7:0] cnt0, last;
    logic [2:0] last_op;
    cnt0 = m_cnt;
    for (int p = 0; p < 256; p++) begin
      last = 8'($urandom); last_op = 3'($urandom);
      bus.sw_data = last; bus.sw_op = last_op;
      bus.btn_load = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (i == 8) begin
          bus.btn_load = 1'b0;
          bus.sw_data = 8'($urandom); bus.sw_op = 3'($urandom);
        end
        tick();
        n_chk++;
        if ({bus.ins, bus.op, bus.load_pulse, bus.load_cnt} !== {m_ins, m_op, m_pulse, m_cnt}) begin
          n_fail++;
          $display("FAIL wrap ins=%h op=%h pulse=%b cnt=%0d required %h %h %b %0d",
                   bus.ins, bus.op, bus.load_pulse, bus.load_cnt, m_ins, m_op, m_pulse, m_cnt);
        end
      end
    end
    n_chk++;
    if (bus.load_cnt !== cnt0 || bus.ins !== last || bus.op !== last_op) begin
      n_fail++;
      $display("FAIL wrap_result cnt=%0d ins=%h op=%h required %0d %h %h",
               bus.load_cnt, bus.ins, bus.op, cnt0, last, last_op);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.sw_data = '0; bus.sw_op = '0; bus.btn_load = 1'b0; bus.btn_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_load();
    test_bounce();
    test_clear();
    test_simultaneous();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
